// File: rtl/seq_arith_datapath.sv
// seq_arith_datapath
// Self-sequenced signed datapath. A start in IDLE captures op_a/op_b plus
// opcode and shamt. The FSM then runs three stages:
//   S1    : compare/abs unit (abs, min, max, pass-through of A) into R4
//   SHIFT : arithmetic right shift of A, one bit per cycle, shamt cycles
//   EXEC  : combine unit (add, sub, and, xor) of R4 and shifted A
// DONE then raises a one-cycle done pulse.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           operation request, sampled only in IDLE
//   op_a, op_b      signed operands (WIDTH bits)
//   opcode          [1:0] stage-1 op, [3:2] stage-2 op
//   shamt           arithmetic right-shift amount applied to A
//   busy            high whenever the FSM is not idle
//   done            one-cycle pulse marking result/ovf valid
//   result, ovf     registered result and overflow/saturation flag
module seq_arith_datapath #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       opcode,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S1    = 3'd1,
        ST_SHIFT = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   ONE_S    = {{(SHW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
    logic [SHW-1:0]   cnt_q, cnt_d, shamt_q, shamt_d;
    logic [3:0]       opc_q, opc_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] au1_s, au2_s, sum_s, diff_s;
    logic             sat_s, ovf2_s;

    // Stage-1 unit: abs/min/max/pass of R1, R2; abs of most-negative saturates
    always_comb begin
        au1_s = r1_q;
        sat_s = 1'b0;
        case (opc_q[1:0])
            2'b00: begin
                if (r1_q == MOST_NEG) begin
                    au1_s = MOST_POS;
                    sat_s = 1'b1;
                end else if (r1_q[WIDTH-1]) begin
                    au1_s = (~r1_q) + ONE_W;
                end else begin
                    au1_s = r1_q;
                end
            end
            2'b01: begin
                if ($signed(r1_q) < $signed(r2_q)) au1_s = r1_q;
                else                               au1_s = r2_q;
            end
            2'b10: begin
                if ($signed(r1_q) > $signed(r2_q)) au1_s = r1_q;
                else                               au1_s = r2_q;
            end
            2'b11:   au1_s = r1_q;
            default: au1_s = r1_q;
        endcase
    end

    // Stage-2 unit: combine R4 with shifted A; add/sub overflow from sign bits
    always_comb begin
        sum_s  = r4_q + r3_q;
        diff_s = r4_q - r3_q;
        au2_s  = sum_s;
        ovf2_s = 1'b0;
        case (opc_q[3:2])
            2'b00: begin
                au2_s  = sum_s;
                ovf2_s = (r4_q[WIDTH-1] == r3_q[WIDTH-1]) &&
                         (sum_s[WIDTH-1] != r4_q[WIDTH-1]);
            end
            2'b01: begin
                au2_s  = diff_s;
                ovf2_s = (r4_q[WIDTH-1] != r3_q[WIDTH-1]) &&
                         (diff_s[WIDTH-1] != r4_q[WIDTH-1]);
            end
            2'b10:   au2_s = r4_q & r3_q;
            2'b11:   au2_s = r4_q ^ r3_q;
            default: au2_s = sum_s;
        endcase
    end

    // Sequencer: next state and next values of every datapath register
    always_comb begin
        state_d  = state_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        r3_d     = r3_q;
        r4_d     = r4_q;
        cnt_d    = cnt_q;
        shamt_d  = shamt_q;
        opc_d    = opc_q;
        sat_d    = sat_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    r1_d    = op_a;
                    r2_d    = op_b;
                    opc_d   = opcode;
                    shamt_d = shamt;
                    state_d = ST_S1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S1: begin
                r4_d  = au1_s;
                sat_d = sat_s;
                r3_d  = r1_q;
                cnt_d = shamt_q;
                if (shamt_q != {SHW{1'b0}}) state_d = ST_SHIFT;
                else                        state_d = ST_EXEC;
            end
            ST_SHIFT: begin
                r3_d  = {r3_q[WIDTH-1], r3_q[WIDTH-1:1]};
                cnt_d = cnt_q - ONE_S;
                // cnt==1 means this edge performs the final shift
                if (cnt_q == ONE_S) state_d = ST_EXEC;
                else                state_d = ST_SHIFT;
            end
            ST_EXEC: begin
                result_d = au2_s;
                ovf_d    = sat_q | ovf2_s;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Status outputs are registered copies decoded from the next state
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            r1_q     <= {WIDTH{1'b0}};
            r2_q     <= {WIDTH{1'b0}};
            r3_q     <= {WIDTH{1'b0}};
            r4_q     <= {WIDTH{1'b0}};
            cnt_q    <= {SHW{1'b0}};
            shamt_q  <= {SHW{1'b0}};
            opc_q    <= 4'b0000;
            sat_q    <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            r3_q     <= r3_d;
            r4_q     <= r4_d;
            cnt_q    <= cnt_d;
            shamt_q  <= shamt_d;
            opc_q    <= opc_d;
            sat_q    <= sat_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_arith_datapath.sv
// Self-checking bench for seq_arith_datapath: an 8-bit and a 16-bit instance.
// Expected results come from an integer reference model and are queued when
// an operation is issued, then popped and compared when done appears.
module tb_seq_arith_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic [3:0]  opc8 = 4'h0, opc16 = 4'h0;
    logic [2:0]  sh8 = 3'd0;
    logic [3:0]  sh16 = 4'd0;
    logic        busy8, done8, ovf8, busy16, done16, ovf16;
    logic [7:0]  res8;
    logic [15:0] res16;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [15:0] res; logic ovf; int lat; } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    seq_arith_datapath #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_a(a8), .op_b(b8),
        .opcode(opc8), .shamt(sh8), .busy(busy8), .done(done8),
        .result(res8), .ovf(ovf8));

    seq_arith_datapath #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op_a(a16), .op_b(b16),
        .opcode(opc16), .shamt(sh16), .busy(busy16), .done(done16),
        .result(res16), .ovf(ovf16));

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sext(input int w, input logic [15:0] v);
        if (w == 8) return int'($signed(v[7:0]));
        else        return int'($signed(v));
    endfunction

    // Integer reference: range checks rather than sign-bit rules for overflow
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] opc, input int sh);
        exp_t e;
        int sa, sb, r4, r3, r, lo, hi, mask;
        bit sat;
        sa = sext(w, a); sb = sext(w, b);
        lo = -(1 << (w - 1)); hi = (1 << (w - 1)) - 1; mask = (1 << w) - 1;
        sat = 1'b0;
        case (opc[1:0])
            2'b00: begin
                if (sa == lo) begin r4 = hi; sat = 1'b1; end
                else r4 = (sa < 0) ? -sa : sa;
            end
            2'b01:   r4 = (sa < sb) ? sa : sb;
            2'b10:   r4 = (sa > sb) ? sa : sb;
            default: r4 = sa;
        endcase
        r3 = sa >>> sh;
        case (opc[3:2])
            2'b00:   r = r4 + r3;
            2'b01:   r = r4 - r3;
            2'b10:   r = r4 & r3;
            default: r = r4 ^ r3;
        endcase
        e.ovf = sat | ((opc[3] == 1'b0) && (r < lo || r > hi));
        e.res = 16'(r & mask);
        e.lat = sh + 3;
        return e;
    endfunction

    // Issue one operation on the chosen instance, then check against the scoreboard
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] opc, input int sh, input string tag);
        int edges;
        exp_t e;
        logic d, bz, o;
        logic [15:0] r;
        @(negedge clk);
        sb_q.push_back(model(w, a, b, opc, sh));
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; opc8 = opc; sh8 = 3'(sh); start8 = 1'b1;
        end else begin
            a16 = a; b16 = b; opc16 = opc; sh16 = 4'(sh); start16 = 1'b1;
        end
        @(posedge clk);
        #1 start8 = 1'b0; start16 = 1'b0;
        edges = 1;
        @(negedge clk);
        bz = (w == 8) ? busy8 : busy16;
        d  = (w == 8) ? done8 : done16;
        chk_value({tag, "_busy"}, 32'(bz), 32'd1);
        while (d == 1'b0 && edges < 40) begin
            @(negedge clk);
            edges++;
            d = (w == 8) ? done8 : done16;
        end
        e = sb_q.pop_front();
        chk_value({tag, "_latency"}, 32'(edges), 32'(e.lat));
        r = (w == 8) ? {8'h00, res8} : res16;
        o = (w == 8) ? ovf8 : ovf16;
        chk_value({tag, "_result"}, 32'(r), 32'(e.res));
        chk_value({tag, "_ovf"}, 32'(o), 32'(e.ovf));
        @(negedge clk);
        d  = (w == 8) ? done8 : done16;
        bz = (w == 8) ? busy8 : busy16;
        chk_value({tag, "_done_pulse"}, 32'(d), 32'd0);
        chk_value({tag, "_idle"}, 32'(bz), 32'd0);
    endtask

    initial begin
        int edges, hits;
        exp_t e;
        #3;
        chk_value("rst8", {busy8, done8, ovf8, 8'h00, res8}, 32'd0);
        chk_value("rst16", {busy16, done16, ovf16, res16}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(8, 16'h00EC, 16'h0005, 4'b0000, 2, "t1");
        chk_value("t1_const", 32'(res8), 32'h0F);
        run_op(8, 16'h00FD, 16'h0007, 4'b0110, 0, "t2");
        chk_value("t2_const", 32'(res8), 32'h0A);
        run_op(8, 16'h0080, 16'h0033, 4'b1100, 7, "t3");
        chk_value("t3_const", {ovf8, res8}, {1'b1, 8'h80});
        run_op(8, 16'h007F, 16'h0001, 4'b0010, 1, "t4");
        chk_value("t4_const", {ovf8, res8}, {1'b1, 8'hBE});
        run_op(16, 16'h8000, 16'h0001, 4'b0101, 15, "t6");
        chk_value("t6_const", {ovf16, res16}, {1'b0, 16'h8001});

        // Starts during SHIFT and DONE are ignored
        @(negedge clk);
        sb_q.push_back(model(8, 16'h00EC, 16'h0005, 4'b0000, 2));
        a8 = 8'hEC; b8 = 8'h05; opc8 = 4'b0000; sh8 = 3'd2; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        edges = 1;
        @(negedge clk);
        @(negedge clk); edges++;
        a8 = 8'h11; b8 = 8'h22; opc8 = 4'b1111; sh8 = 3'd1; start8 = 1'b1;
        @(negedge clk); edges++;
        start8 = 1'b0;
        while (done8 == 1'b0 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        e = sb_q.pop_front();
        chk_value("t5_latency", 32'(edges), 32'(e.lat));
        chk_value("t5_result", {ovf8, res8}, {e.ovf, e.res[7:0]});
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk_value("t5_done_start_ignored", 32'(busy8), 32'd0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done8) hits++;
        end
        chk_value("t5_single_done", 32'(hits), 32'd0);

        // Asynchronous reset in the middle of SHIFT aborts the operation
        a8 = 8'h40; b8 = 8'h01; opc8 = 4'b0011; sh8 = 3'd5; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk_value("t5_in_shift_busy", 32'(busy8), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_value("t5_abort", {busy8, done8, ovf8, res8}, 11'd0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (done8) hits++;
        end
        chk_value("t5_no_done_after_abort", 32'(hits), 32'd0);
        run_op(8, 16'h00EC, 16'h0005, 4'b0000, 2, "t5_restart");

        // Random operations on both widths
        for (int i = 0; i < 24; i++)
            run_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                   4'($urandom_range(0, 15)), $urandom_range(0, 7), "rnd8");
        for (int i = 0; i < 8; i++)
            run_op(16, 16'($urandom), 16'($urandom),
                   4'($urandom_range(0, 15)), $urandom_range(0, 15), "rnd16");
        run_op(8, 16'h0080, 16'h0080, 4'b0001, 0, "edge_minneg_add");
        run_op(8, 16'h0080, 16'h0001, 4'b0111, 0, "edge_pass_sub");

        chk_value("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_arith_datapath.md
Name: seq_arith_datapath

Overview:
- Parametrised, self-sequenced successor of the 8-bit LogicCore9 datapath.
- Captures two signed operands and runs three stages: a compare/abs unit, a variable arithmetic right shift done one bit per cycle, and a combine unit.
- An internal FSM runs the whole sequence, so the external controller only issues start, opcode and shift amount, then waits for done.
- Sits between the operand input bus and the result bus.

Parameters:
- WIDTH, 8, operand/result width in bits, two's complement, minimum 4.
- SHW, $clog2(WIDTH), width of the shift-amount port (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  signed operand A.
- op_b  input  WIDTH  signed operand B.
- opcode  input  4  [1:0] stage-1 op; [3:2] stage-2 op.
- shamt  input  SHW  arithmetic right-shift amount applied to A (0..WIDTH-1).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result and ovf valid.
- result  output  WIDTH  signed result; held until the next EXEC.
- ovf  output  1  overflow/saturation flag for this result.

Behaviour:
- Reset is asynchronous. It forces state=IDLE, clears all internal registers (R1, R2, R3, R4, cnt, opcode/shamt copies), and sets result=0, ovf=0, done=0, busy=0.
- States: IDLE, S1, SHIFT, EXEC, DONE.
- IDLE:
  - With start=1 at a clock edge: R1<=op_a, R2<=op_b, latch opcode and shamt, go to S1.
  - start is ignored in every other state. Inputs are don't-care after capture.
- S1 (one cycle):
  - R4 <= AU1(R1,R2), selected by opcode[1:0]:
    - 00: abs(R1)
    - 01: signed min(R1,R2)
    - 10: signed max(R1,R2)
    - 11: R1 pass-through
  - abs of the most-negative value (-2^(WIDTH-1)) saturates to 2^(WIDTH-1)-1 and sets internal sat=1. Otherwise sat=0.
  - R3<=R1 and cnt<=shamt. Next state is SHIFT if shamt!=0, else EXEC.
- SHIFT:
  - Each cycle: R3 <= R3>>>1 (sign bit replicated), cnt<=cnt-1.
  - Leave for EXEC on the edge where cnt==1. Exactly shamt shift cycles are performed.
- EXEC (one cycle):
  - result <= AU2(R4,R3), selected by opcode[3:2]:
    - 00: R4+R3
    - 01: R4-R3
    - 10: R4&R3
    - 11: R4^R3
  - Add/sub wrap modulo 2^WIDTH.
  - ovf <= sat | signed overflow of add/sub (operands same sign for add, or opposite signs for sub, and result sign differs from R4). Logic ops contribute 0.
  - Go to DONE.
- DONE (one cycle): done=1, busy=1. Next state is IDLE. A start seen in DONE is ignored.
- Latency: done is high exactly shamt+3 clock edges after the edge that sampled start. Back-to-back throughput is one operation per shamt+4 cycles.
- Outputs are registered. done is decoded from the state register, glitch-free.
- Reset mid-operation (any state) aborts: no done pulse, result and ovf return to 0.

Test Plan (WIDTH=8 unless stated):
1. A=0xEC(-20), B=0x05, opcode=0000, shamt=2, start -> done pulse at edge 5 after start. abs=20, shifted A=0xFB(-5), result=0x0F, ovf=0. busy high for edges 1-5.
2. A=0xFD(-3), B=0x07, opcode=0110 (max, sub), shamt=0 -> done at edge 3. result=0x0A, ovf=0. SHIFT state never entered.
3. A=0x80, B=don't-care, opcode=1100 (abs, xor), shamt=7 -> abs saturates to 0x7F, shifted A=0xFF. result=0x80, ovf=1, done at edge 10.
4. A=0x7F, B=0x01, opcode=0010 (max, add), shamt=1 -> 127+63 wraps to result=0xBE, ovf=1.
5. Start from case 1, pulse start again during SHIFT and in DONE -> both ignored, exactly one done. Then assert rst during SHIFT of a second op -> busy=0, done=0, result=0, ovf=0 immediately; the next start runs normally.
6. WIDTH=16: A=0x8000, B=0x0001, opcode=0101 (min, sub), shamt=15 -> min=0x8000, shifted A=0xFFFF. result=0x8001, ovf=0, done at edge 18.
